ramarb: RTL and testbench

Round-robin arbiter that shares the single RAM port between up to eight requesters: the sequence controller, port/DMA engines and debug access. It sits between the requesters and the RAM chip-select/data path. It grants one requester at a time and enforces a one-cycle bus turnaround between owners. A hold-timeout reclaims the RAM from a requester that never releases it.

---
 rtl/ramarb.sv | 131 +++++++++++++
 tb/tb_ramarb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ramarb.sv
// ramarb: round-robin arbiter for the shared RAM port. It inserts a one-cycle bus turnaround
// between owners and uses a hold timeout that masks a requester until it drops its request.
module ramarb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [2:0]      OWNER,
  output logic            RAM_CS,
  output logic            BUSY,
  output logic            TMO
);

  localparam int unsigned N = NREQ;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RECOVER} state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            cs_q, cs_d;
  logic            busy_q, busy_d;
  logic            tmo_q, tmo_d;

  logic [NREQ-1:0] elig;
  logic            req_own, at_limit;
  logic            win_any, hi_any, lo_any;
  logic [2:0]      hi_idx, lo_idx, win_idx, win_ptr;

  assign elig     = REQ & ~mask_q;
  assign req_own  = |(REQ & gnt_q);
  assign at_limit = (cnt_q == 8'(TIMEOUT - 1));

  // Rotating scan split in two: first eligible at/above ptr, else first eligible overall (wrap).
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (elig[j] && !lo_any) begin
        lo_any = 1'b1;
        lo_idx = 3'(j);
      end
      if (elig[j] && !hi_any && (j >= 32'(ptr_q))) begin
        hi_any = 1'b1;
        hi_idx = 3'(j);
      end
    end
    win_any = lo_any;
    win_idx = hi_any ? hi_idx : lo_idx;
    win_ptr = (win_idx == 3'(N - 1)) ? 3'd0 : win_idx + 3'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q & REQ;
    unique case (state_q)
      S_IDLE, S_RECOVER: begin
        cnt_d = '0;
        if (win_any) begin
          state_d = S_GRANT;
          owner_d = win_idx;
          ptr_d   = win_ptr;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (!req_own) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
        end else if (at_limit) begin
          state_d = S_RECOVER;
          cnt_d   = '0;
          mask_d  = mask_d | gnt_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_d  = (state_d == S_GRANT) ? (NREQ'(1) << owner_d) : '0;
    cs_d   = (state_d == S_GRANT);
    busy_d = (state_d != S_IDLE);
    tmo_d  = (state_q == S_GRANT) && req_own && at_limit;
  end

  assign GNT    = gnt_q;
  assign OWNER  = owner_q;
  assign RAM_CS = cs_q;
  assign BUSY   = busy_q;
  assign TMO    = tmo_q;

endmodule

// File: tb/tb_ramarb.sv
// Bench for ramarb: two instances (4 req / timeout 16 and 2 req / timeout 2) checked every
// cycle against an integer-level ownership model, plus directed scenarios and random traffic.
module tb_ramarb;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] req_a;
  logic [1:0] req_b;
  logic [3:0] gnt_a;
  logic [1:0] gnt_b;
  logic [2:0] owner_a, owner_b;
  logic       cs_a, cs_b, busy_a, busy_b, tmo_a, tmo_b;

  always #5 CLK = ~CLK;

  ramarb #(.NREQ(4), .TIMEOUT(16)) u_a (
    .CLK(CLK), .RST(RST), .REQ(req_a), .GNT(gnt_a), .OWNER(owner_a),
    .RAM_CS(cs_a), .BUSY(busy_a), .TMO(tmo_a)
  );

  ramarb #(.NREQ(2), .TIMEOUT(2)) u_b (
    .CLK(CLK), .RST(RST), .REQ(req_b), .GNT(gnt_b), .OWNER(owner_b),
    .RAM_CS(cs_b), .BUSY(busy_b), .TMO(tmo_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: who holds the bus, how many cycles so far, whether a turnaround is pending.
  int         m_own  [2];
  int         m_hold [2];
  int         m_last [2];
  int         m_ptr  [2];
  bit         m_gap  [2];
  bit         m_tmo  [2];
  logic [7:0] m_mask [2];

  function automatic bit bit_of(input logic [7:0] v, input int i);
    logic [2:0] s;
    s = i[2:0];
    return v[s];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_hold[k] = 0;
      m_last[k] = 0;
      m_ptr[k]  = 0;
      m_gap[k]  = 1'b0;
      m_tmo[k]  = 1'b0;
      m_mask[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input int n, input int lim, input logic [7:0] r);
    int w;
    w = -1;
    m_tmo[k] = 1'b0;
    for (int i = 0; i < n; i++)
      if (!bit_of(r, i)) m_mask[k] = m_mask[k] & ~(8'd1 << i);
    if (m_own[k] >= 0) begin
      if (!bit_of(r, m_own[k])) begin
        m_own[k] = -1;
        m_gap[k] = 1'b1;
      end else if (m_hold[k] == lim) begin
        m_mask[k] = m_mask[k] | (8'd1 << m_own[k]);
        m_tmo[k]  = 1'b1;
        m_own[k]  = -1;
        m_gap[k]  = 1'b1;
      end else begin
        m_hold[k]++;
      end
    end else begin
      for (int s = 0; s < n; s++) begin
        int i;
        i = (m_ptr[k] + s) % n;
        if (w < 0 && bit_of(r, i) && !bit_of(m_mask[k], i)) w = i;
      end
      m_gap[k] = 1'b0;
      if (w >= 0) begin
        m_own[k]  = w;
        m_hold[k] = 1;
        m_last[k] = w;
        m_ptr[k]  = (w + 1) % n;
      end
    end
  endtask

  function automatic logic [31:0] exp_gnt(input int k);
    return (m_own[k] >= 0) ? (32'd1 << m_own[k]) : 32'd0;
  endfunction

  task automatic compare_all();
    check("gnt_a",   32'(gnt_a),   exp_gnt(0));
    check("owner_a", 32'(owner_a), 32'(m_last[0]));
    check("cs_a",    32'(cs_a),    32'(m_own[0] >= 0));
    check("busy_a",  32'(busy_a),  32'((m_own[0] >= 0) || m_gap[0]));
    check("tmo_a",   32'(tmo_a),   32'(m_tmo[0]));
    check("gnt_b",   32'(gnt_b),   exp_gnt(1));
    check("owner_b", 32'(owner_b), 32'(m_last[1]));
    check("cs_b",    32'(cs_b),    32'(m_own[1] >= 0));
    check("busy_b",  32'(busy_b),  32'((m_own[1] >= 0) || m_gap[1]));
    check("tmo_b",   32'(tmo_b),   32'(m_tmo[1]));
  endtask

  logic [1:0] rb_q = 2'b11;

  // Instance b requesters mostly hold high and occasionally drop for a cycle.
  function automatic logic [1:0] next_b();
    logic [1:0] v;
    v[0] = ($urandom_range(4) != 0);
    v[1] = ($urandom_range(4) != 0);
    return v;
  endfunction

  task automatic tick(input logic [3:0] ra);
    req_a = ra;
    req_b = rb_q;
    @(posedge CLK);
    model_step(0, 4, 16, {4'b0, ra});
    model_step(1, 2, 2, {6'b0, rb_q});
    #1;
    compare_all();
    rb_q = next_b();
  endtask

  task automatic do_reset();
    #2 RST = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge CLK);
    #2 RST = 1'b1;
  endtask

  int         done_cnt [4];
  bit         done     [4];
  int         order_q  [$];
  int         gnt2_cycles, tmo_pulses, gnt3_seen;
  logic [3:0] ra, prev_g;

  initial begin
    RST   = 1'b0;
    req_a = '0;
    req_b = '0;
    model_reset();
    #1 compare_all();
    @(posedge CLK);
    #2 RST = 1'b1;

    // Single requester 1 for 5 cycles, then release through RECOVER to IDLE.
    for (int c = 0; c < 5; c++) tick(4'b0010);
    for (int c = 0; c < 3; c++) tick(4'b0000);

    // All four request; each drops after 2 grant cycles. Expect order 0,1,2,3.
    do_reset();
    for (int i = 0; i < 4; i++) begin done_cnt[i] = 0; done[i] = 1'b0; end
    prev_g = '0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 4; i++) ra[i] = !done[i];
      tick(ra);
      if (gnt_a != 4'b0 && gnt_a != prev_g) order_q.push_back(int'(owner_a));
      prev_g = gnt_a;
      for (int i = 0; i < 4; i++)
        if (m_own[0] == i) begin
          done_cnt[i]++;
          if (done_cnt[i] == 2) done[i] = 1'b1;
        end
    end
    check("rr_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++) check("rr_order", 32'(order_q[i]), 32'(i));

    // Requester 2 never releases: exactly 16 grant cycles, one TMO, no regrant until REQ toggles.
    gnt2_cycles = 0;
    tmo_pulses  = 0;
    for (int c = 0; c < 40; c++) begin
      tick(4'b0100);
      if (gnt_a[2]) gnt2_cycles++;
      if (tmo_a) tmo_pulses++;
    end
    check("tmo_hold", 32'(gnt2_cycles), 32'd16);
    check("tmo_once", 32'(tmo_pulses), 32'd1);
    tick(4'b0000);
    for (int c = 0; c < 4; c++) tick(4'b0100);
    check("regrant", 32'(gnt_a), 32'b0100);
    for (int c = 0; c < 3; c++) tick(4'b0000);

    // Owner 0 holding while requester 3 pulses; 3 is never granted and ptr moves to 1.
    do_reset();
    gnt3_seen = 0;
    for (int c = 0; c < 3; c++) tick(4'b0001);
    for (int c = 0; c < 2; c++) tick(4'b1001);
    for (int c = 0; c < 2; c++) tick(4'b0001);
    for (int c = 0; c < 4; c++) begin
      tick(4'b0000);
      if (gnt_a[3]) gnt3_seen++;
    end
    tick(4'b1010);
    check("ptr_adv", 32'(gnt_a), 32'b0010);
    check("no_gnt3", 32'(gnt3_seen), 32'd0);
    for (int c = 0; c < 3; c++) tick(4'b0000);

    // Asynchronous reset while requester 2 owns the bus at hold count 7.
    for (int c = 0; c < 8; c++) tick(4'b0100);
    check("pre_rst_own", 32'(owner_a), 32'd2);
    req_a = 4'b0000;
    do_reset();
    check("rst_gnt", 32'(gnt_a), 32'd0);
    tick(4'b0110);
    check("post_rst", 32'(gnt_a), 32'b0010);
    for (int c = 0; c < 3; c++) tick(4'b0000);

    // Random traffic: fast toggling first, then long holds to reach timeouts.
    ra = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range((c < 700) ? 7 : 39) == 0) ra[i] = ~ra[i];
      tick(ra);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
